// File: rtl/param_transpose_buffer.sv
// Ping-pong N x N transpose buffer between the row-DCT and column-DCT stages.
// Rows are written one per beat into one bank while the other bank is read
// out one column per beat (or one row per beat in pass-through mode).
module param_transpose_buffer #(
    parameter int N      = 8,
    parameter int DATA_W = 12
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [N*DATA_W-1:0] i_data,
    input  logic                i_mode,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [N*DATA_W-1:0] o_data,
    output logic                o_last
);

    localparam int            CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    // Sample storage: two banks of N rows, each row a packed beat.
    logic [N*DATA_W-1:0] bank_q [2][N];

    logic [1:0]    full_q,   full_d;
    logic [1:0]    mode_q,   mode_d;
    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic          in_accept;
    logic          out_accept;

    // Handshake flags come straight from registered bank state, so neither
    // ready nor valid depends combinationally on the opposite side.
    assign o_ready    = ~full_q[wr_sel_q];
    assign o_valid    = full_q[rd_sel_q];
    assign o_last     = o_valid & (rd_cnt_q == LAST_IDX);
    assign in_accept  = i_valid & o_ready;
    assign out_accept = o_valid & i_ready;

    // Next-state for bank flags, bank selects and row/column counters.
    always_comb begin
        full_d   = full_q;
        mode_d   = mode_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (in_accept) begin
            wr_cnt_d = wr_cnt_q + ONE;
            if (wr_cnt_q == '0) begin
                mode_d[wr_sel_q] = i_mode;
            end
            if (wr_cnt_q == LAST_IDX) begin
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = ~wr_sel_q;
            end
        end
        if (out_accept) begin
            rd_cnt_d = rd_cnt_q + ONE;
            if (rd_cnt_q == LAST_IDX) begin
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = ~rd_sel_q;
            end
        end
    end

    // Control registers; reset drops every partial and completed block.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            full_q   <= '0;
            mode_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            full_q   <= full_d;
            mode_q   <= mode_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // Bank write port; storage is deliberately left unreset.
    always_ff @(posedge i_clk) begin
        if (in_accept) begin
            bank_q[wr_sel_q][wr_cnt_q] <= i_data;
        end
    end

    // Read mux: column rd_cnt across all rows, or row rd_cnt as stored.
    always_comb begin
        o_data = '0;
        for (int j = 0; j < N; j++) begin
            if (mode_q[rd_sel_q]) begin
                o_data[j*DATA_W +: DATA_W] = bank_q[rd_sel_q][rd_cnt_q][j*DATA_W +: DATA_W];
            end else begin
                o_data[j*DATA_W +: DATA_W] = bank_q[rd_sel_q][CW'(j)][int'(rd_cnt_q)*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: doc/param_transpose_buffer.md
Name: param_transpose_buffer

Overview:
Parametrised ping-pong N×N transpose buffer for the DCT path. It sits between the row-DCT stage and the column-DCT stage. It accepts one row of N samples per beat and emits one column per beat, with valid/ready handshakes on both sides. A per-block mode can select pass-through (row order) instead of transpose.

Parameters:
N, 8, block dimension: rows per block and samples per beat; power of two, 2..16.
DATA_W, 12, signed sample width in bits.

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_valid  input  1  input beat valid.
o_ready  output  1  buffer can accept an input beat.
i_data  input  N*DATA_W  input row; element j = i_data[j*DATA_W +: DATA_W].
i_mode  input  1  0 = transpose, 1 = pass-through; sampled on the first beat of each block.
o_valid  output  1  output beat valid.
i_ready  input  1  downstream accepts the output beat.
o_data  output  N*DATA_W  output beat; element j = o_data[j*DATA_W +: DATA_W].
o_last  output  1  high on the final (N-th) output beat of a block.

Behaviour:
- Storage and control
  - Two banks, each N×N×DATA_W. Bank storage is not reset.
  - Per-bank control: full flag and mode bit.
  - Global control: wr_sel, rd_sel, wr_cnt, rd_cnt (each counter log2(N) bits).
- Reset (async, i_rst_n=0)
  - full[1:0]=0, wr_sel=0, rd_sel=0, wr_cnt=0, rd_cnt=0.
  - Outputs: o_valid=0, o_last=0, o_ready=1. o_data is don't-care while o_valid=0.
  - Reset asserted mid-block discards all partial and full blocks. No output beat follows reset until N new input beats are accepted.
- Write side
  - o_ready = ~full[wr_sel], decoded only from registers (no combinational path from i_valid or i_ready).
  - Input accept = i_valid & o_ready. On accept:
    - row wr_cnt of bank wr_sel <= i_data;
    - if wr_cnt==0, mode[wr_sel] <= i_mode;
    - wr_cnt increments.
  - On the accept with wr_cnt==N-1: full[wr_sel] <= 1, wr_sel toggles, wr_cnt wraps to 0.
  - i_mode on non-first beats is ignored.
  - i_valid with o_ready=0 is not an accept. Upstream must hold its data.
- Read side
  - o_valid = full[rd_sel].
  - Transpose mode: o_data element j = bank[rd_sel] row j element rd_cnt.
  - Pass-through mode: o_data element j = bank[rd_sel] row rd_cnt element j.
  - o_last = o_valid & (rd_cnt==N-1).
  - Output accept = o_valid & i_ready; rd_cnt increments on accept.
  - On the accept with rd_cnt==N-1: full[rd_sel] <= 0, rd_sel toggles, rd_cnt wraps to 0.
  - While o_valid=1 and i_ready=0, o_data, o_last and rd_cnt hold stable.
- Latency and throughput
  - First output beat is valid the cycle after the N-th input beat of a block is accepted.
  - With i_valid=i_ready=1 continuously, throughput is 1 beat/cycle in and out with no bubbles after the first block.
- Boundary cases
  - Both banks full: o_ready=0.
  - Read of bank X completing in the same cycle wr_sel points at X: o_ready rises the following cycle (registered flag). This causes no throughput loss in steady state, because the writer is on the other bank.
  - A write completion and a read completion in the same cycle touch different banks and both take effect.
  - Write and read never target the same bank concurrently. Guaranteed by the full flags.
- Arithmetic
  - Samples pass through bit-exact; no arithmetic, no sign extension.
  - Counters wrap modulo N.

Test Plan:
- Basic transpose: N=8, DATA_W=12, i_mode=0. Row r element c = 12'h0RC (e.g. r=2,c=5 -> 12'h025); 8 beats, i_ready=1 -> 8 output beats starting the cycle after the 8th accept. Beat k element j = 12'h0jk. o_last only on beat 7.
- Pass-through: same stimulus, i_mode=1 on beat 0 and i_mode=0 on beats 1..7 -> output beat k equals input row k; mode held for the whole block.
- Streaming: 4 back-to-back blocks, i_valid=i_ready=1 continuously -> o_ready never drops, 32 contiguous output beats, blocks alternate banks, no bubble after cycle 8.
- Backpressure: i_ready=0 from cycle 8, 17 input beats offered -> exactly 16 accepted, o_ready=0 from the cycle after the 16th accept. o_data holds beat 0 of block 0. After i_ready=1, blocks drain in order; the 17th beat is accepted the cycle after the first bank frees.
- Output stall mid-block: i_ready toggles 1,0,0,1,... -> rd_cnt advances only on accept, o_data is stable during stalls, and beat order is unchanged.
- Async reset mid-operation: i_rst_n=0 for 1 cycle after 5 beats of block 1 and with block 0 half-read -> o_valid=0 immediately, o_ready=1. The next 8 inputs yield exactly one clean transposed block.
